// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arb_pkg : shared types and width defaults for the RAM arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int unsigned c_ADDR_WIDTH = 4;
    localparam int unsigned c_DATA_WIDTH = 8;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Values double as bit positions in the request vector.
    typedef enum logic [1:0] {
        REQ_F = 2'd0,
        REQ_D = 2'd1,
        REQ_P = 2'd2
    } req_id_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arb_if : requester handshakes and RAM-side bus of mem_arbiter
// Program-loader signals exist only with MEM_ARB_PROG_EN.  Rev 1.0
// ----------------------------------------------------------------------------
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = c_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = c_ADDR_WIDTH
);
    logic                  i_f_req;
    logic [ADDR_WIDTH-1:0] i_f_addr;
    logic                  o_f_gnt;
    logic                  o_f_rvalid;
    logic [DATA_WIDTH-1:0] o_f_rdata;

    logic                  i_d_req;
    logic                  i_d_we;
    logic                  i_d_jmp;
    logic [ADDR_WIDTH-1:0] i_d_addr;
    logic [DATA_WIDTH-1:0] i_d_wdata;
    logic                  o_d_gnt;
    logic                  o_d_rvalid;
    logic [DATA_WIDTH-1:0] o_d_rdata;

    logic                  o_ram_we;
    logic                  o_ram_jmp;
    logic [DATA_WIDTH-1:0] o_ram_addr;
    logic [DATA_WIDTH-1:0] o_ram_wdata;
    logic [DATA_WIDTH-1:0] i_ram_rdata;

`ifdef MEM_ARB_PROG_EN
    logic                  i_p_req;
    logic [ADDR_WIDTH-1:0] i_p_addr;
    logic [DATA_WIDTH-1:0] i_p_wdata;
    logic                  o_p_gnt;
`endif

    modport slave (
        input  i_f_req, i_f_addr,
        output o_f_gnt, o_f_rvalid, o_f_rdata,
        input  i_d_req, i_d_we, i_d_jmp, i_d_addr, i_d_wdata,
        output o_d_gnt, o_d_rvalid, o_d_rdata,
        output o_ram_we, o_ram_jmp, o_ram_addr, o_ram_wdata,
        input  i_ram_rdata
`ifdef MEM_ARB_PROG_EN
        , input  i_p_req, i_p_addr, i_p_wdata
        , output o_p_gnt
`endif
    );

    modport master (
        output i_f_req, i_f_addr,
        input  o_f_gnt, o_f_rvalid, o_f_rdata,
        output i_d_req, i_d_we, i_d_jmp, i_d_addr, i_d_wdata,
        input  o_d_gnt, o_d_rvalid, o_d_rdata,
        input  o_ram_we, o_ram_jmp, o_ram_addr, o_ram_wdata,
        output i_ram_rdata
`ifdef MEM_ARB_PROG_EN
        , output i_p_req, i_p_addr, i_p_wdata
        , input  o_p_gnt
`endif
    );

endinterface
`default_nettype wire

// File: rtl/mem_arb_rr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arb_rr : winner select, loader first, then round-robin fetch/data
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [2:0] i_req,
    input  logic       i_last_d,
    output logic       o_valid,
    output req_id_t    o_winner
);

    always_comb begin
        o_valid  = |i_req;
        o_winner = REQ_F;
        if (i_req[REQ_P]) begin
            o_winner = REQ_P;
        end else if (i_req[REQ_F] && i_req[REQ_D]) begin
            o_winner = i_last_d ? REQ_F : REQ_D;
        end else if (i_req[REQ_D]) begin
            o_winner = REQ_D;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter : two-cycle shared access to the single-port program/data RAM
// MEM_ARB_PROG_EN adds a highest-priority write-only loader port.  Rev 1.0
// ----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = c_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = c_ADDR_WIDTH
) (
    input  logic     i_clk,
    input  logic     i_rst,
    mem_arb_if.slave bus
);

    localparam int unsigned c_PAD = DATA_WIDTH - ADDR_WIDTH;

    state_t                r_state,     w_state_nxt;
    req_id_t               r_winner,    w_winner_nxt;
    logic                  r_last_d,    w_last_d_nxt;
    logic                  r_f_gnt,     w_f_gnt_nxt;
    logic                  r_d_gnt,     w_d_gnt_nxt;
    logic                  r_f_rvalid,  w_f_rvalid_nxt;
    logic                  r_d_rvalid,  w_d_rvalid_nxt;
    logic [DATA_WIDTH-1:0] r_f_rdata,   w_f_rdata_nxt;
    logic [DATA_WIDTH-1:0] r_d_rdata,   w_d_rdata_nxt;
    logic                  r_ram_we,    w_ram_we_nxt;
    logic                  r_ram_jmp,   w_ram_jmp_nxt;
    logic [DATA_WIDTH-1:0] r_ram_addr,  w_ram_addr_nxt;
    logic [DATA_WIDTH-1:0] r_ram_wdata, w_ram_wdata_nxt;
`ifdef MEM_ARB_PROG_EN
    logic                  r_p_gnt,     w_p_gnt_nxt;
`endif

    logic [2:0] w_req;
    logic       w_grant_valid;
    req_id_t    w_grant_id;

`ifdef MEM_ARB_PROG_EN
    assign w_req = {bus.i_p_req, bus.i_d_req, bus.i_f_req};
`else
    assign w_req = {1'b0, bus.i_d_req, bus.i_f_req};
`endif

    mem_arb_rr u_rr (
        .i_req    (w_req),
        .i_last_d (r_last_d),
        .o_valid  (w_grant_valid),
        .o_winner (w_grant_id)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_winner_nxt    = r_winner;
        w_last_d_nxt    = r_last_d;
        w_f_gnt_nxt     = 1'b0;
        w_d_gnt_nxt     = 1'b0;
        w_f_rvalid_nxt  = 1'b0;
        w_d_rvalid_nxt  = 1'b0;
        w_f_rdata_nxt   = r_f_rdata;
        w_d_rdata_nxt   = r_d_rdata;
        w_ram_we_nxt    = 1'b0;
        w_ram_jmp_nxt   = 1'b0;
        w_ram_addr_nxt  = '0;
        w_ram_wdata_nxt = '0;
`ifdef MEM_ARB_PROG_EN
        w_p_gnt_nxt     = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_state_nxt  = ST_ACCESS;
                    w_winner_nxt = w_grant_id;
                    case (w_grant_id)
                        REQ_F: begin
                            w_f_gnt_nxt    = 1'b1;
                            w_last_d_nxt   = 1'b0;
                            w_ram_addr_nxt = {{c_PAD{1'b0}}, bus.i_f_addr};
                        end
                        REQ_D: begin
                            w_d_gnt_nxt     = 1'b1;
                            w_last_d_nxt    = 1'b1;
                            w_ram_addr_nxt  = {{c_PAD{1'b0}}, bus.i_d_addr};
                            w_ram_we_nxt    = bus.i_d_we;
                            w_ram_jmp_nxt   = bus.i_d_jmp & ~bus.i_d_we;
                            w_ram_wdata_nxt = bus.i_d_we ? bus.i_d_wdata : '0;
                        end
`ifdef MEM_ARB_PROG_EN
                        // Loader grants leave the fetch/data fairness pointer untouched.
                        REQ_P: begin
                            w_p_gnt_nxt     = 1'b1;
                            w_ram_addr_nxt  = {{c_PAD{1'b0}}, bus.i_p_addr};
                            w_ram_we_nxt    = 1'b1;
                            w_ram_wdata_nxt = bus.i_p_wdata;
                        end
`endif
                        default: w_state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_ACCESS: begin
                w_state_nxt = ST_IDLE;
                if (r_winner == REQ_F) begin
                    w_f_rvalid_nxt = 1'b1;
                    w_f_rdata_nxt  = bus.i_ram_rdata;
                end else if (r_winner == REQ_D && !r_ram_we) begin
                    w_d_rvalid_nxt = 1'b1;
                    w_d_rdata_nxt  = r_ram_jmp ? {{(DATA_WIDTH-4){1'b0}}, bus.i_ram_rdata[3:0]}
                                               : bus.i_ram_rdata;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_winner    <= REQ_F;
            r_last_d    <= 1'b1;
            r_f_gnt     <= 1'b0;
            r_d_gnt     <= 1'b0;
            r_f_rvalid  <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_f_rdata   <= '0;
            r_d_rdata   <= '0;
            r_ram_we    <= 1'b0;
            r_ram_jmp   <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
`ifdef MEM_ARB_PROG_EN
            r_p_gnt     <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_winner    <= w_winner_nxt;
            r_last_d    <= w_last_d_nxt;
            r_f_gnt     <= w_f_gnt_nxt;
            r_d_gnt     <= w_d_gnt_nxt;
            r_f_rvalid  <= w_f_rvalid_nxt;
            r_d_rvalid  <= w_d_rvalid_nxt;
            r_f_rdata   <= w_f_rdata_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
            r_ram_we    <= w_ram_we_nxt;
            r_ram_jmp   <= w_ram_jmp_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_wdata <= w_ram_wdata_nxt;
`ifdef MEM_ARB_PROG_EN
            r_p_gnt     <= w_p_gnt_nxt;
`endif
        end
    end

    assign bus.o_f_gnt     = r_f_gnt;
    assign bus.o_f_rvalid  = r_f_rvalid;
    assign bus.o_f_rdata   = r_f_rdata;
    assign bus.o_d_gnt     = r_d_gnt;
    assign bus.o_d_rvalid  = r_d_rvalid;
    assign bus.o_d_rdata   = r_d_rdata;
    assign bus.o_ram_we    = r_ram_we;
    assign bus.o_ram_jmp   = r_ram_jmp;
    assign bus.o_ram_addr  = r_ram_addr;
    assign bus.o_ram_wdata = r_ram_wdata;
`ifdef MEM_ARB_PROG_EN
    assign bus.o_p_gnt     = r_p_gnt;
`endif

endmodule
`default_nettype wire
